// File: rtl/fb_arbiter_if.sv
// Frame-buffer arbiter bus: video reader, game requester and single RAM port.
// master = requesters/RAM side, slave = arbiter side.
interface fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 3
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_rvalid;
  logic              gm_req;
  logic              gm_we;
  logic [ADDR_W-1:0] gm_addr;
  logic [DATA_W-1:0] gm_wdata;
  logic              gm_gnt;
  logic [DATA_W-1:0] gm_rdata;
  logic              gm_rvalid;
  logic              game_starve;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_write_enabled;
  logic [DATA_W-1:0] ram_write_data;
  logic [DATA_W-1:0] ram_read_data;

  modport master (
    output vid_req, vid_addr, gm_req, gm_we, gm_addr, gm_wdata, ram_read_data,
    input  vid_rdata, vid_rvalid, gm_gnt, gm_rdata, gm_rvalid, game_starve,
           ram_address, ram_write_enabled, ram_write_data
  );

  modport slave (
    input  vid_req, vid_addr, gm_req, gm_we, gm_addr, gm_wdata, ram_read_data,
    output vid_rdata, vid_rvalid, gm_gnt, gm_rdata, gm_rvalid, game_starve,
           ram_address, ram_write_enabled, ram_write_data
  );
endinterface

// File: rtl/fb_arbiter.sv
// Frame-buffer arbiter: video scan-out (strict priority) and game logic share one RAM port.
// Define FB_ARBITER_STATS_EN to add the stall-cycle and video-read statistics counters.
module fb_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 3,
  parameter int STARVE_LIMIT = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  fb_arbiter_if.slave bus
`ifdef FB_ARBITER_STATS_EN
  ,
  output logic [31:0] stat_stall_cycles,
  output logic [31:0] stat_vid_reads
`endif
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_VID,
    TAG_GRD
  } tag_e;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              gnt_q, gnt_d;
  tag_e              t1_q, t1_d;
  tag_e              t2_q, t2_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              starve_q, starve_d;
  logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
  logic [DATA_W-1:0] gm_rdata_q, gm_rdata_d;
  logic              vid_win;
  logic              gm_win;
  logic              vid_ret;
  logic              gm_ret;
`ifdef FB_ARBITER_STATS_EN
  logic [31:0]       stall_q, stall_d;
  logic [31:0]       vreads_q, vreads_d;
`endif

  // A grant visible this cycle blocks the game so a held request is never issued twice.
  assign vid_win = bus.vid_req;
  assign gm_win  = !bus.vid_req && bus.gm_req && !gnt_q;
  assign vid_ret = (t2_q == TAG_VID);
  assign gm_ret  = (t2_q == TAG_GRD);

  always_comb begin
    addr_d      = addr_q;
    we_d        = 1'b0;
    wdata_d     = '0;
    gnt_d       = gm_win;
    t1_d        = TAG_NONE;
    t2_d        = t1_q;
    wait_d      = '0;
    starve_d    = starve_q;
    vid_rdata_d = vid_rdata_q;
    gm_rdata_d  = gm_rdata_q;
`ifdef FB_ARBITER_STATS_EN
    stall_d     = stall_q;
    vreads_d    = vreads_q;
`endif

    if (vid_win) begin
      addr_d = bus.vid_addr;
      t1_d   = TAG_VID;
    end else if (gm_win) begin
      addr_d = bus.gm_addr;
      we_d   = bus.gm_we;
      if (bus.gm_we) begin
        wdata_d = bus.gm_wdata;
      end else begin
        t1_d = TAG_GRD;
      end
    end

    if (bus.gm_req && !gm_win) begin
      wait_d = (wait_q == CNT_MAX) ? wait_q : wait_q + CNT_W'(1);
    end
    if (wait_d == CNT_MAX) begin
      starve_d = 1'b1;
    end

    // RAM data arrives in the same cycle the tag reaches T2, so it is passed straight through.
    if (vid_ret) begin
      vid_rdata_d = bus.ram_read_data;
    end
    if (gm_ret) begin
      gm_rdata_d = bus.ram_read_data;
    end

`ifdef FB_ARBITER_STATS_EN
    if (bus.gm_req && !gm_win && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
    if (vid_win) begin
      vreads_d = vreads_q + 32'd1;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      gnt_q       <= 1'b0;
      t1_q        <= TAG_NONE;
      t2_q        <= TAG_NONE;
      wait_q      <= '0;
      starve_q    <= 1'b0;
      vid_rdata_q <= '0;
      gm_rdata_q  <= '0;
`ifdef FB_ARBITER_STATS_EN
      stall_q     <= '0;
      vreads_q    <= '0;
`endif
    end else begin
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      gnt_q       <= gnt_d;
      t1_q        <= t1_d;
      t2_q        <= t2_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      vid_rdata_q <= vid_rdata_d;
      gm_rdata_q  <= gm_rdata_d;
`ifdef FB_ARBITER_STATS_EN
      stall_q     <= stall_d;
      vreads_q    <= vreads_d;
`endif
    end
  end

  assign bus.ram_address       = addr_q;
  assign bus.ram_write_enabled = we_q;
  assign bus.ram_write_data    = wdata_q;
  assign bus.gm_gnt            = gnt_q;
  assign bus.game_starve       = starve_q;
  assign bus.vid_rvalid        = vid_ret;
  assign bus.vid_rdata         = vid_rdata_d;
  assign bus.gm_rvalid         = gm_ret;
  assign bus.gm_rdata          = gm_rdata_d;
`ifdef FB_ARBITER_STATS_EN
  assign stat_stall_cycles     = stall_q;
  assign stat_vid_reads        = vreads_q;
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: vector table plus scoreboarded read returns,
// starvation, interleave, random and reset sequences. FB_ARBITER_STATS_EN covers the counters.
module tb_fb_arbiter;
  localparam int ADDR_W       = 19;
  localparam int DATA_W       = 3;
  localparam int STARVE_LIMIT = 64;
  localparam int NUM_VECS     = 16;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  typedef struct {
    logic              vr;
    logic [ADDR_W-1:0] va;
    logic              gr;
    logic              gwe;
    logic [ADDR_W-1:0] ga;
    logic [DATA_W-1:0] gwd;
    logic              eGnt;
    logic              eWe;
    logic [ADDR_W-1:0] eAddr;
    logic [DATA_W-1:0] eWd;
  } vec_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef FB_ARBITER_STATS_EN
  logic [31:0] stat_stall_cycles;
  logic [31:0] stat_vid_reads;
`endif

  fb_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
`ifdef FB_ARBITER_STATS_EN
    ,
    .stat_stall_cycles(stat_stall_cycles),
    .stat_vid_reads(stat_vid_reads)
`endif
  );

  logic [DATA_W-1:0] ramMem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] refMem [logic [ADDR_W-1:0]];
  exp_t              vidQ[$];
  exp_t              gmQ[$];
  int                cycle;
  int                compared;
  int                mismatched;
  logic              gntExp;
  logic              weExp;
  logic [ADDR_W-1:0] addrExp;
  logic [DATA_W-1:0] wdataExp;
  int                waitExp;
  logic              starveExp;
  logic [DATA_W-1:0] lastVid;
  logic [DATA_W-1:0] lastGm;
  logic [31:0]       stallExp;
  logic [31:0]       vidReadsExp;
  vec_t              vecs [NUM_VECS];

  always #5 clock = ~clock;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return a[2:0] ^ a[5:3] ^ a[8:6];
  endfunction

  function automatic logic [DATA_W-1:0] ramRead(input logic [ADDR_W-1:0] a);
    return ramMem.exists(a) ? ramMem[a] : pat(a);
  endfunction

  function automatic logic [DATA_W-1:0] refRead(input logic [ADDR_W-1:0] a);
    return refMem.exists(a) ? refMem[a] : pat(a);
  endfunction

  // Synchronous single-port RAM, preloaded with pat(); data valid the cycle after the address
  always @(posedge clock) begin
    bus.ram_read_data <= ramRead(bus.ram_address);
    if (bus.ram_write_enabled) begin
      ramMem[bus.ram_address] = bus.ram_write_data;
    end
  end

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    logic expV;
    logic expG;
    checkEq("gm_gnt", 32'(bus.gm_gnt), 32'(gntExp));
    checkEq("ram_write_enabled", 32'(bus.ram_write_enabled), 32'(weExp));
    checkEq("ram_address", 32'(bus.ram_address), 32'(addrExp));
    checkEq("ram_write_data", 32'(bus.ram_write_data), 32'(wdataExp));
    checkEq("game_starve", 32'(bus.game_starve), 32'(starveExp));
    expV = (vidQ.size() > 0) && (vidQ[0].due == cycle);
    checkEq("vid_rvalid", 32'(bus.vid_rvalid), 32'(expV));
    if (expV) begin
      e = vidQ.pop_front();
      lastVid = e.data;
    end
    checkEq("vid_rdata", 32'(bus.vid_rdata), 32'(lastVid));
    expG = (gmQ.size() > 0) && (gmQ[0].due == cycle);
    checkEq("gm_rvalid", 32'(bus.gm_rvalid), 32'(expG));
    if (expG) begin
      e = gmQ.pop_front();
      lastGm = e.data;
    end
    checkEq("gm_rdata", 32'(bus.gm_rdata), 32'(lastGm));
`ifdef FB_ARBITER_STATS_EN
    checkEq("stat_stall_cycles", stat_stall_cycles, stallExp);
    checkEq("stat_vid_reads", stat_vid_reads, vidReadsExp);
`endif
  endtask

  // Drives one cycle of inputs, predicts the issue and pushes expected read returns
  task automatic applyStimulus(input logic vr, input logic [ADDR_W-1:0] va, input logic gr,
                               input logic gwe, input logic [ADDR_W-1:0] ga,
                               input logic [DATA_W-1:0] gwd);
    logic              win;
    logic              nGnt;
    logic              nWe;
    logic [ADDR_W-1:0] nAddr;
    logic [DATA_W-1:0] nWd;
    exp_t              e;
    bus.vid_req  = vr;
    bus.vid_addr = va;
    bus.gm_req   = gr;
    bus.gm_we    = gwe;
    bus.gm_addr  = ga;
    bus.gm_wdata = gwd;
    win   = !vr && gr && !gntExp;
    nGnt  = win;
    nWe   = 1'b0;
    nWd   = '0;
    nAddr = addrExp;
    if (vr) begin
      nAddr  = va;
      e.data = refRead(va);
      e.due  = cycle + 2;
      vidQ.push_back(e);
      vidReadsExp = vidReadsExp + 32'd1;
    end else if (win) begin
      nAddr = ga;
      if (gwe) begin
        nWe        = 1'b1;
        nWd        = gwd;
        refMem[ga] = gwd;
      end else begin
        e.data = refRead(ga);
        e.due  = cycle + 2;
        gmQ.push_back(e);
      end
    end
    if (gr && !win) begin
      if (waitExp < STARVE_LIMIT) waitExp++;
      if (stallExp != 32'hFFFF_FFFF) stallExp = stallExp + 32'd1;
    end else begin
      waitExp = 0;
    end
    if (waitExp == STARVE_LIMIT) starveExp = 1'b1;
    @(posedge clock);
    #1;
    cycle++;
    gntExp   = nGnt;
    weExp    = nWe;
    addrExp  = nAddr;
    wdataExp = nWd;
    checkOutput();
  endtask

  task automatic resetDut();
    reset_n      = 1'b0;
    bus.vid_req  = 1'b0;
    bus.vid_addr = '0;
    bus.gm_req   = 1'b0;
    bus.gm_we    = 1'b0;
    bus.gm_addr  = '0;
    bus.gm_wdata = '0;
    #1;
    gntExp      = 1'b0;
    weExp       = 1'b0;
    addrExp     = '0;
    wdataExp    = '0;
    waitExp     = 0;
    starveExp   = 1'b0;
    lastVid     = '0;
    lastGm      = '0;
    stallExp    = '0;
    vidReadsExp = '0;
    vidQ.delete();
    gmQ.delete();
    checkOutput();
    @(posedge clock);
    #1;
    cycle++;
    checkOutput();
    reset_n = 1'b1;
  endtask

  initial begin
    logic              pend;
    logic              gwe;
    logic [ADDR_W-1:0] ga;
    logic [DATA_W-1:0] gwd;
    logic              vr;
    logic [ADDR_W-1:0] va;

    compared   = 0;
    mismatched = 0;
    cycle      = 0;

    // vr, va, gr, gwe, ga, gwd  ->  gnt, we, addr, wdata in the following cycle
    vecs[0]  = '{1'b0, 19'd0,  1'b1, 1'b1, 19'd1000, 3'd5, 1'b1, 1'b1, 19'd1000, 3'd5};
    vecs[1]  = '{1'b0, 19'd0,  1'b0, 1'b0, 19'd0,    3'd0, 1'b0, 1'b0, 19'd1000, 3'd0};
    vecs[2]  = '{1'b0, 19'd0,  1'b1, 1'b0, 19'd1000, 3'd0, 1'b1, 1'b0, 19'd1000, 3'd0};
    vecs[3]  = '{1'b0, 19'd0,  1'b0, 1'b0, 19'd0,    3'd0, 1'b0, 1'b0, 19'd1000, 3'd0};
    vecs[4]  = '{1'b0, 19'd0,  1'b0, 1'b0, 19'd0,    3'd0, 1'b0, 1'b0, 19'd1000, 3'd0};
    vecs[5]  = '{1'b1, 19'd7,  1'b1, 1'b0, 19'd5,    3'd0, 1'b0, 1'b0, 19'd7,    3'd0};
    vecs[6]  = '{1'b0, 19'd0,  1'b1, 1'b0, 19'd5,    3'd0, 1'b1, 1'b0, 19'd5,    3'd0};
    vecs[7]  = '{1'b0, 19'd0,  1'b0, 1'b0, 19'd0,    3'd0, 1'b0, 1'b0, 19'd5,    3'd0};
    vecs[8]  = '{1'b0, 19'd0,  1'b0, 1'b0, 19'd0,    3'd0, 1'b0, 1'b0, 19'd5,    3'd0};
    vecs[9]  = '{1'b1, 19'd9,  1'b1, 1'b1, 19'd9,    3'd2, 1'b0, 1'b0, 19'd9,    3'd0};
    vecs[10] = '{1'b1, 19'd10, 1'b1, 1'b1, 19'd9,    3'd2, 1'b0, 1'b0, 19'd10,   3'd0};
    vecs[11] = '{1'b0, 19'd0,  1'b1, 1'b1, 19'd9,    3'd2, 1'b1, 1'b1, 19'd9,    3'd2};
    vecs[12] = '{1'b0, 19'd0,  1'b1, 1'b0, 19'd9,    3'd0, 1'b0, 1'b0, 19'd9,    3'd0};
    vecs[13] = '{1'b0, 19'd0,  1'b1, 1'b0, 19'd9,    3'd0, 1'b1, 1'b0, 19'd9,    3'd0};
    vecs[14] = '{1'b0, 19'd0,  1'b0, 1'b0, 19'd0,    3'd0, 1'b0, 1'b0, 19'd9,    3'd0};
    vecs[15] = '{1'b0, 19'd0,  1'b0, 1'b0, 19'd0,    3'd0, 1'b0, 1'b0, 19'd9,    3'd0};

    #2;
    resetDut();

    $display("[TB] vector table: write, read-back, collision, back-to-back");
    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].vr, vecs[i].va, vecs[i].gr, vecs[i].gwe, vecs[i].ga, vecs[i].gwd);
      checkEq($sformatf("vec%0d_gnt", i), 32'(bus.gm_gnt), 32'(vecs[i].eGnt));
      checkEq($sformatf("vec%0d_we", i), 32'(bus.ram_write_enabled), 32'(vecs[i].eWe));
      checkEq($sformatf("vec%0d_addr", i), 32'(bus.ram_address), 32'(vecs[i].eAddr));
      checkEq($sformatf("vec%0d_wdata", i), 32'(bus.ram_write_data), 32'(vecs[i].eWd));
    end

    $display("[TB] starvation under continuous video");
    for (int i = 0; i < 70; i++) begin
      applyStimulus(1'b1, 19'(3000 + i), 1'b1, 1'b0, 19'd300, 3'd0);
    end
    checkEq("starve_after_70", 32'(bus.game_starve), 32'd1);
    applyStimulus(1'b0, 19'd0, 1'b1, 1'b0, 19'd300, 3'd0);
    checkEq("starve_game_granted", 32'(bus.gm_gnt), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 19'd0, 1'b0, 1'b0, 19'd0, 3'd0);
    end
    checkEq("starve_sticky", 32'(bus.game_starve), 32'd1);
    resetDut();
    checkEq("starve_cleared", 32'(bus.game_starve), 32'd0);

    $display("[TB] interleaved video and game read stream");
    ga = 19'd2000;
    for (int i = 0; i < 40; i++) begin
      applyStimulus((i % 2) == 0, 19'(4000 + i), 1'b1, 1'b0, ga, 3'd0);
      if (gntExp) ga = ga + 19'd1;
    end
    checkEq("stream_progress", 32'(ga), 32'd2020);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 19'd0, 1'b0, 1'b0, 19'd0, 3'd0);
    end

    $display("[TB] random traffic on a small address window");
    pend = 1'b0;
    gwe  = 1'b0;
    ga   = '0;
    gwd  = '0;
    for (int i = 0; i < 300; i++) begin
      if (!pend && ($urandom_range(0, 2) != 0)) begin
        pend = 1'b1;
        gwe  = 1'($urandom_range(0, 1));
        ga   = 19'($urandom_range(0, 15));
        gwd  = 3'($urandom_range(0, 7));
      end
      vr = ($urandom_range(0, 2) == 0);
      va = 19'($urandom_range(0, 15));
      applyStimulus(vr, va, pend, gwe, ga, gwd);
      if (gntExp) pend = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 19'd0, 1'b0, 1'b0, 19'd0, 3'd0);
    end

    $display("[TB] reset during an in-flight game read");
    applyStimulus(1'b0, 19'd0, 1'b1, 1'b0, 19'd20, 3'd0);
    resetDut();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 19'd0, 1'b0, 1'b0, 19'd0, 3'd0);
    end
    checkEq("post_reset_no_rvalid", 32'(bus.gm_rvalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
